// File: rtl/display_timing_gen.sv
// rtl/display_timing_gen.sv - pixel timing generator; optional o_line via DISPLAY_TIMING_LINE_STROBE_EN
module display_timing_gen #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_sx,
  output logic [15:0] o_sy,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
  ,
  output logic        o_line
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // Counters are 16 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_chk
    $error("display_timing_gen: H_TOTAL or V_TOTAL exceeds 65535");
  end

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT      = 16'(H_RES);
  localparam logic [15:0] V_ACT      = 16'(V_RES);
  localparam logic [15:0] H_SYNC_LO  = 16'(H_RES + H_FP);
  localparam logic [15:0] H_SYNC_HI  = 16'(H_RES + H_FP + H_SYNC);
  localparam logic [15:0] V_SYNC_LO  = 16'(V_RES + V_FP);
  localparam logic [15:0] V_SYNC_HI  = 16'(V_RES + V_FP + V_SYNC);

  logic [15:0] r_sx;
  logic [15:0] r_sy;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_frame;
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
  logic        r_line;
`endif

  logic [15:0] w_sx_next;
  logic [15:0] w_sy_next;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_de_next;
  logic        w_frame_next;

  // Next position after one step, plus the decoded flags for that new position
  always_comb begin
    w_h_wrap  = (r_sx == H_LAST);
    w_v_wrap  = (r_sy == V_LAST);
    w_sx_next = w_h_wrap ? 16'd0 : r_sx + 16'd1;
    w_sy_next = r_sy;
    if (w_h_wrap) begin
      w_sy_next = w_v_wrap ? 16'd0 : r_sy + 16'd1;
    end
    w_hs_on      = (w_sx_next >= H_SYNC_LO) && (w_sx_next < H_SYNC_HI);
    w_vs_on      = (w_sy_next >= V_SYNC_LO) && (w_sy_next < V_SYNC_HI);
    w_de_next    = (w_sx_next < H_ACT) && (w_sy_next < V_ACT);
    w_frame_next = (w_sx_next == 16'd0) && (w_sy_next == 16'd0);
  end

  // Position and all strobes register together so they always describe the same pixel
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sx    <= H_LAST;
      r_sy    <= V_LAST;
      r_hs    <= ~H_POL;
      r_vs    <= ~V_POL;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
      r_line  <= 1'b0;
`endif
    end else if (i_en) begin
      r_sx    <= w_sx_next;
      r_sy    <= w_sy_next;
      r_hs    <= w_hs_on ? H_POL : ~H_POL;
      r_vs    <= w_vs_on ? V_POL : ~V_POL;
      r_de    <= w_de_next;
      r_frame <= w_frame_next;
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
      r_line  <= (w_sx_next == 16'd0);
`endif
    end
  end

  assign o_sx    = r_sx;
  assign o_sy    = r_sy;
  assign o_hs    = r_hs;
  assign o_vs    = r_vs;
  assign o_de    = r_de;
  assign o_frame = r_frame;
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
  assign o_line  = r_line;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// tb/tb_display_timing_gen.sv - scoreboard bench for display_timing_gen (default and small configs)
module tb_display_timing_gen;

  localparam int D_HR = 640, D_HF = 16, D_HS = 96, D_HT = 800;
  localparam int D_VR = 480, D_VF = 10, D_VS = 2,  D_VT = 525;
  localparam int S_HR = 8,   S_HF = 2,  S_HS = 3,  S_HT = 15;
  localparam int S_VR = 4,   S_VF = 1,  S_VS = 2,  S_VT = 8;

  typedef struct packed {
    logic [15:0] sx;
    logic [15:0] sy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        frame;
    logic        line;
  } obs_t;

  typedef struct {
    obs_t d;
    obs_t s;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [15:0] d_sx, d_sy, s_sx, s_sy;
  logic        d_hs, d_vs, d_de, d_frame, d_line;
  logic        s_hs, s_vs, s_de, s_frame, s_line;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t mon_e;
  int   m_dx, m_dy, m_sx, m_sy;
  bit   seg1 = 1'b0;
  int   hs_cnt = 0, de_cnt = 0, sx0_cnt = 0, sf_cnt = 0, svs_cnt = 0;

  always #5 clk = ~clk;

  display_timing_gen dut (
    .i_pix_clk (clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .o_sx      (d_sx),
    .o_sy      (d_sy),
    .o_hs      (d_hs),
    .o_vs      (d_vs),
    .o_de      (d_de),
    .o_frame   (d_frame)
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
    ,
    .o_line    (d_line)
`endif
  );

  display_timing_gen #(
    .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(2),
    .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .i_pix_clk (clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .o_sx      (s_sx),
    .o_sy      (s_sy),
    .o_hs      (s_hs),
    .o_vs      (s_vs),
    .o_de      (s_de),
    .o_frame   (s_frame)
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
    ,
    .o_line    (s_line)
`endif
  );

`ifndef DISPLAY_TIMING_LINE_STROBE_EN
  assign d_line = 1'b0;
  assign s_line = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got sx=%0d sy=%0d hs=%0b vs=%0b de=%0b frame=%0b line=%0b expected sx=%0d sy=%0d hs=%0b vs=%0b de=%0b frame=%0b line=%0b",
               name, act.sx, act.sy, act.hs, act.vs, act.de, act.frame, act.line,
               exp.sx, exp.sy, exp.hs, exp.vs, exp.de, exp.frame, exp.line);
    end
  endtask

  function automatic obs_t mk(input int sx, input int sy,
                              input int hr, input int hf, input int hsw,
                              input int vr, input int vf, input int vsw,
                              input bit hp, input bit vp);
    obs_t o;
    o.sx    = 16'(sx);
    o.sy    = 16'(sy);
    o.hs    = (sx >= hr + hf && sx < hr + hf + hsw) ? hp : ~hp;
    o.vs    = (sy >= vr + vf && sy < vr + vf + vsw) ? vp : ~vp;
    o.de    = (sx < hr) && (sy < vr);
    o.frame = (sx == 0) && (sy == 0);
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
    o.line  = (sx == 0);
`else
    o.line  = 1'b0;
`endif
    return o;
  endfunction

  task automatic adv(inout int x, inout int y, input int ht, input int vt);
    if (x == ht - 1) begin
      x = 0;
      y = (y == vt - 1) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  // One rising edge: update the reference position and queue what the DUTs must show
  task automatic clk_step();
    exp_t e;
    @(posedge clk);
    #1;
    if (i_rst) begin
      m_dx = D_HT - 1; m_dy = D_VT - 1;
      m_sx = S_HT - 1; m_sy = S_VT - 1;
    end else if (i_en) begin
      adv(m_dx, m_dy, D_HT, D_VT);
      adv(m_sx, m_sy, S_HT, S_VT);
    end
    e.d = mk(m_dx, m_dy, D_HR, D_HF, D_HS, D_VR, D_VF, D_VS, 1'b0, 1'b0);
    e.s = mk(m_sx, m_sy, S_HR, S_HF, S_HS, S_VR, S_VF, S_VS, 1'b1, 1'b1);
    q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sx"},    int'(d_sx), 799);
    check({tag, "_sy"},    int'(d_sy), 524);
    check({tag, "_hs"},    int'(d_hs), 1);
    check({tag, "_vs"},    int'(d_vs), 1);
    check({tag, "_de"},    int'(d_de), 0);
    check({tag, "_frame"}, int'(d_frame), 0);
    check({tag, "_s_sx"},  int'(s_sx), 14);
    check({tag, "_s_sy"},  int'(s_sy), 7);
    check({tag, "_s_hs"},  int'(s_hs), 0);
  endtask

  // Monitor: compare every presented sample against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check_obs("dflt", {d_sx, d_sy, d_hs, d_vs, d_de, d_frame, d_line}, mon_e.d);
      check_obs("small", {s_sx, s_sy, s_hs, s_vs, s_de, s_frame, s_line}, mon_e.s);
      if (seg1) begin
        if (d_sy == 16'd1 && !d_hs) hs_cnt++;
        if (d_sy == 16'd1 && d_de)  de_cnt++;
        if (d_sx == 16'd0)          sx0_cnt++;
        if (s_frame)                sf_cnt++;
        if (s_vs)                   svs_cnt++;
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_en  = 1'b1;
    m_dx = 0; m_dy = 0; m_sx = 0; m_sy = 0;

    repeat (3) clk_step();
    settle();
    check_reset_vals("rst_hold");

    i_rst = 1'b0;
    seg1  = 1'b1;
    clk_step();
    settle();
    check("first_sx", int'(d_sx), 0);
    check("first_sy", int'(d_sy), 0);
    check("first_de", int'(d_de), 1);
    check("first_frame", int'(d_frame), 1);
    check("first_s_frame", int'(s_frame), 1);
`ifdef DISPLAY_TIMING_LINE_STROBE_EN
    check("first_line", int'(d_line), 1);
`endif

    repeat (8655) clk_step();
    settle();
    seg1 = 1'b0;
    check("at655_sx", int'(d_sx), 655);
    check("at655_sy", int'(d_sy), 10);
    check("at655_hs", int'(d_hs), 1);
    check("at655_s_sx", int'(s_sx), 0);
    check("at655_s_sy", int'(s_sy), 1);
    check("at655_s_hs", int'(s_hs), 0);

    i_en = 1'b0;
    repeat (2) clk_step();
    settle();
    check("hold_sx", int'(d_sx), 655);
    check("hold_sy", int'(d_sy), 10);
    check("hold_hs", int'(d_hs), 1);

    i_en = 1'b1;
    clk_step();
    settle();
    check("step656_sx", int'(d_sx), 656);
    check("step656_hs", int'(d_hs), 0);

    repeat (444) clk_step();
    settle();
    check("mid_sx", int'(d_sx), 300);
    check("mid_sy", int'(d_sy), 11);

    i_rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (2) clk_step();

    i_rst = 1'b0;
    clk_step();
    settle();
    check("restart_sx", int'(d_sx), 0);
    check("restart_sy", int'(d_sy), 0);
    check("restart_frame", int'(d_frame), 1);

    for (int k = 0; k < 900; k++) begin
      i_en = (k % 3 != 2);
      clk_step();
    end
    i_en = 1'b1;
    settle();

    check("queue_drained", q.size(), 0);
    check("line1_hs_low_cycles", hs_cnt, 96);
    check("line1_de_cycles", de_cnt, 640);
    check("sx0_samples", sx0_cnt, 11);
    check("small_frame_pulses", sf_cnt, 73);
    check("small_vs_cycles", svs_cnt, 2160);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
